// File: rtl/scoreboard.sv
// scoreboard: register-busy tracker for the decode stage.
// Keeps one small pending-write counter per architectural register. The decoder
// commits destinations; ALU/LSU writebacks release them. Source queries read
// back "busy" when a write is still outstanding. Register x0 is never tracked.
// Optional feature macro: SCOREBOARD_BYPASS_EN (same-cycle release bypasses
// into the query answers). Without it, answers come from the registered
// counters only.
module scoreboard #(
  parameter int RFADDR = 5,
  parameter int NREGS  = 2**RFADDR,
  parameter int CNT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [RFADDR-1:0] query_1_i,
  input  logic [RFADDR-1:0] query_2_i,
  output logic              query_answer_1_o,
  output logic              query_answer_2_o,
  input  logic [RFADDR-1:0] commit_i,
  input  logic              rel_alu_valid_i,
  input  logic [RFADDR-1:0] rel_alu_addr_i,
  input  logic              rel_lsu_valid_i,
  input  logic [RFADDR-1:0] rel_lsu_addr_i,
  input  logic              flush_i,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Number of releases hitting one register in a cycle (0..2).
  function automatic logic [1:0] release_count(input logic alu_hit, input logic lsu_hit);
    return {1'b0, alu_hit} + {1'b0, lsu_hit};
  endfunction

  // Registered state
  logic [CNT_W-1:0] cnt_r [NREGS];
  logic             err_r;

  // Per-register next-state terms
  logic [NREGS-1:0] inc_s;
  logic [1:0]       dec_s  [NREGS];
  logic [CNT_W:0]   sum_s  [NREGS];
  logic [CNT_W:0]   diff_s [NREGS];
  logic [CNT_W-1:0] cnt_next_s [NREGS];
  logic [NREGS-1:0] ovf_s;
  logic [NREGS-1:0] unf_s;
  logic             err_event_s;

  // Compute each register's clamped next count and its overflow/underflow flags.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      inc_s[r]      = 1'b0;
      dec_s[r]      = 2'd0;
      sum_s[r]      = {(CNT_W+1){1'b0}};
      diff_s[r]     = {(CNT_W+1){1'b0}};
      cnt_next_s[r] = CNT_ZERO;
      ovf_s[r]      = 1'b0;
      unf_s[r]      = 1'b0;
      if (r != 0) begin
        inc_s[r] = (commit_i == RFADDR'(r));
        dec_s[r] = release_count(rel_alu_valid_i && (rel_alu_addr_i == RFADDR'(r)),
                                 rel_lsu_valid_i && (rel_lsu_addr_i == RFADDR'(r)));
        sum_s[r] = {1'b0, cnt_r[r]} + {{CNT_W{1'b0}}, inc_s[r]};
        if (sum_s[r] < (CNT_W+1)'(dec_s[r])) begin
          // More releases than outstanding writes: clamp to idle and flag.
          unf_s[r]      = 1'b1;
          cnt_next_s[r] = CNT_ZERO;
        end else begin
          diff_s[r] = sum_s[r] - (CNT_W+1)'(dec_s[r]);
          if (diff_s[r] > {1'b0, CNT_MAX}) begin
            // Commit on a full counter with no release: hold at max and flag.
            ovf_s[r]      = 1'b1;
            cnt_next_s[r] = CNT_MAX;
          end else begin
            cnt_next_s[r] = diff_s[r][CNT_W-1:0];
          end
        end
      end else begin
        // x0 is hardwired idle; its commits and releases are silently dropped.
        cnt_next_s[r] = CNT_ZERO;
      end
    end
  end

  // Any tracked register over- or under-flowing this cycle.
  always_comb begin
    err_event_s = 1'b0;
    if ((|ovf_s) || (|unf_s)) begin
      err_event_s = 1'b1;
    end else begin
      err_event_s = 1'b0;
    end
  end

  // Counter and sticky error registers; reset beats flush, flush beats updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      err_r <= 1'b0;
    end else if (flush_i) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      err_r <= err_r;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_r[r] <= cnt_next_s[r];
      end
      err_r <= err_r | err_event_s;
    end
  end

`ifdef SCOREBOARD_BYPASS_EN
  // Busy answers from the next count, so a same-cycle release frees the source.
  always_comb begin
    query_answer_1_o = 1'b0;
    query_answer_2_o = 1'b0;
    if (cnt_next_s[query_1_i] != CNT_ZERO) begin
      query_answer_1_o = 1'b1;
    end else begin
      query_answer_1_o = 1'b0;
    end
    if (cnt_next_s[query_2_i] != CNT_ZERO) begin
      query_answer_2_o = 1'b1;
    end else begin
      query_answer_2_o = 1'b0;
    end
  end
`else
  // Busy answers straight from the registered counters.
  always_comb begin
    query_answer_1_o = 1'b0;
    query_answer_2_o = 1'b0;
    if (cnt_r[query_1_i] != CNT_ZERO) begin
      query_answer_1_o = 1'b1;
    end else begin
      query_answer_1_o = 1'b0;
    end
    if (cnt_r[query_2_i] != CNT_ZERO) begin
      query_answer_2_o = 1'b1;
    end else begin
      query_answer_2_o = 1'b0;
    end
  end
`endif

  assign err_o = err_r;

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard (default build, bypass disabled).
// Reference model: integer pending counts per register, updated by the
// arithmetic rule cnt + commits - releases clamped to 0..max.
module tb_scoreboard;

  localparam int CMAX = 3;

  logic       clk;
  logic       rst_i;
  logic [4:0] query_1_i, query_2_i;
  logic       query_answer_1_o, query_answer_2_o;
  logic [4:0] commit_i;
  logic       rel_alu_valid_i, rel_lsu_valid_i;
  logic [4:0] rel_alu_addr_i, rel_lsu_addr_i;
  logic       flush_i;
  logic       err_o;

  int  nvec = 0;
  int  nerr = 0;
  int  model_cnt [32];
  bit  model_err;

  scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .query_1_i       (query_1_i),
    .query_2_i       (query_2_i),
    .query_answer_1_o(query_answer_1_o),
    .query_answer_2_o(query_answer_2_o),
    .commit_i        (commit_i),
    .rel_alu_valid_i (rel_alu_valid_i),
    .rel_alu_addr_i  (rel_alu_addr_i),
    .rel_lsu_valid_i (rel_lsu_valid_i),
    .rel_lsu_addr_i  (rel_lsu_addr_i),
    .flush_i         (flush_i),
    .err_o           (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit model_busy(input logic [4:0] q);
    return (q != 5'd0) && (model_cnt[q] != 0);
  endfunction

  task automatic drive(input logic [4:0] c, input logic av, input logic [4:0] aa,
                       input logic lv, input logic [4:0] la, input logic fl);
    commit_i        = c;
    rel_alu_valid_i = av;
    rel_alu_addr_i  = aa;
    rel_lsu_valid_i = lv;
    rel_lsu_addr_i  = la;
    flush_i         = fl;
  endtask

  // Advance one clock: update the model from the driven inputs, then idle inputs.
  task automatic tick();
    int n, inc, dec;
    if (rst_i) begin
      for (int r = 0; r < 32; r++) model_cnt[r] = 0;
      model_err = 1'b0;
    end else if (flush_i) begin
      for (int r = 0; r < 32; r++) model_cnt[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc = (commit_i == r) ? 1 : 0;
        dec = ((rel_alu_valid_i && rel_alu_addr_i == r) ? 1 : 0) +
              ((rel_lsu_valid_i && rel_lsu_addr_i == r) ? 1 : 0);
        n = model_cnt[r] + inc - dec;
        if (n < 0) begin
          n = 0; model_err = 1'b1;
        end else if (n > CMAX) begin
          n = CMAX; model_err = 1'b1;
        end
        model_cnt[r] = n;
      end
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    query_1_i = 5'd5; query_2_i = 5'd6; #1;
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL reset_q1 got %b want 0", query_answer_1_o); end
    nvec++; if (query_answer_2_o !== 1'b0) begin nerr++; $display("FAIL reset_q2 got %b want 0", query_answer_2_o); end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", err_o); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);  // commit x0 and release x0 twice
    tick();
    query_1_i = 5'd0; query_2_i = 5'd0; #1;
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL x0_q1 got %b want 0", query_answer_1_o); end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL x0_err got %b want 0", err_o); end
  endtask

  task automatic test_commit_release();
    do_reset();
    drive(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);   // cycle 1: commit x5
    tick();
    query_1_i = 5'd5; query_2_i = 5'd6; #1;      // cycle 2
    nvec++; if (query_answer_1_o !== 1'b1) begin nerr++; $display("FAIL raw_busy got %b want 1", query_answer_1_o); end
    nvec++; if (query_answer_2_o !== 1'b0) begin nerr++; $display("FAIL raw_other got %b want 0", query_answer_2_o); end
    tick();
    drive(5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);   // cycle 3: ALU releases x5
    #1;
    nvec++; if (query_answer_1_o !== 1'b1) begin nerr++; $display("FAIL rel_same_cycle got %b want 1", query_answer_1_o); end
    tick();                                      // cycle 4
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL rel_next_cycle got %b want 0", query_answer_1_o); end
  endtask

  task automatic test_multi_pending();
    do_reset();
    query_1_i = 5'd7; query_2_i = 5'd7;
    drive(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    drive(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    drive(5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0); tick();  // LSU release, cnt 2 -> 1
    #1;
    nvec++; if (query_answer_2_o !== 1'b1) begin nerr++; $display("FAIL multi_still_busy got %b want 1", query_answer_2_o); end
    drive(5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0); tick();  // ALU release, cnt 1 -> 0
    #1;
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL multi_idle got %b want 0", query_answer_1_o); end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL multi_err got %b want 0", err_o); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    query_1_i = 5'd9; query_2_i = 5'd9;
    drive(5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    drive(5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0); tick();  // net zero
    #1;
    nvec++; if (query_answer_1_o !== 1'b1) begin nerr++; $display("FAIL net0_busy got %b want 1", query_answer_1_o); end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL net0_err got %b want 0", err_o); end
    drive(5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0); tick();  // double release, cnt 1
    #1;
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL underflow_idle got %b want 0", query_answer_1_o); end
    nvec++; if (err_o !== 1'b1) begin nerr++; $display("FAIL underflow_err got %b want 1", err_o); end
    drive(5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();  // keeps working after error
    #1;
    nvec++; if (err_o !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b want 1", err_o); end
    nvec++; if (query_answer_1_o !== 1'b1) begin nerr++; $display("FAIL after_err_busy got %b want 1", query_answer_1_o); end
  endtask

  task automatic test_saturate();
    do_reset();
    query_1_i = 5'd3; query_2_i = 5'd3;
    for (int i = 0; i < 3; i++) begin
      drive(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    end
    #1;
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL sat_full_noerr got %b want 0", err_o); end
    drive(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();  // fourth commit overflows
    #1;
    nvec++; if (err_o !== 1'b1) begin nerr++; $display("FAIL sat_err got %b want 1", err_o); end
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (query_answer_1_o !== 1'b1) begin nerr++; $display("FAIL sat_busy_%0d got %b want 1", i, query_answer_1_o); end
      drive(5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0); tick();
    end
    #1;
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL sat_idle got %b want 0", query_answer_1_o); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    drive(5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    query_1_i = 5'd4; query_2_i = 5'd8; #1;
    nvec++; if (query_answer_1_o !== 1'b1 || query_answer_2_o !== 1'b1) begin
      nerr++; $display("FAIL preflush got %b%b want 11", query_answer_1_o, query_answer_2_o); end
    drive(5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); tick();
    #1;
    nvec++; if (query_answer_1_o !== 1'b0 || query_answer_2_o !== 1'b0) begin
      nerr++; $display("FAIL flush_x4x8 got %b%b want 00", query_answer_1_o, query_answer_2_o); end
    query_1_i = 5'd10; #1;
    nvec++; if (query_answer_1_o !== 1'b0) begin nerr++; $display("FAIL flush_x10 got %b want 0", query_answer_1_o); end
    // flush leaves a raised error in place
    drive(5'd0, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0); tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); tick();
    #1;
    nvec++; if (err_o !== 1'b1) begin nerr++; $display("FAIL flush_keeps_err got %b want 1", err_o); end
  endtask

  task automatic test_reset_override();
    drive(5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    rst_i = 1'b1;
    drive(5'd13, 1'b1, 5'd2, 1'b1, 5'd2, 1'b1);
    tick();
    for (int a = 0; a < 32; a++) begin
      query_1_i = 5'(a); query_2_i = 5'(31 - a); #1;
      nvec++; if (query_answer_1_o !== 1'b0 || query_answer_2_o !== 1'b0) begin
        nerr++; $display("FAIL rst_override_q%0d got %b%b want 00", a, query_answer_1_o, query_answer_2_o); end
    end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL rst_override_err got %b want 0", err_o); end
  endtask

  task automatic test_random();
    logic [4:0] c, aa, la;
    logic av, lv, fl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c  = (($urandom_range(0, 2)) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      av = ($urandom_range(0, 2) == 0);
      lv = ($urandom_range(0, 3) == 0);
      aa = 5'($urandom_range(0, 7));
      la = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 39) == 0);
      if (i == 200) begin
        rst_i = 1'b1;
      end
      drive(c, av, aa, lv, la, fl);
      query_1_i = 5'($urandom_range(0, 8));
      query_2_i = 5'($urandom_range(0, 8));
      #1;
      nvec++; if (query_answer_1_o !== model_busy(query_1_i)) begin
        nerr++; $display("FAIL rand_q1 cyc%0d addr %0d got %b want %b", i, query_1_i, query_answer_1_o, model_busy(query_1_i)); end
      nvec++; if (query_answer_2_o !== model_busy(query_2_i)) begin
        nerr++; $display("FAIL rand_q2 cyc%0d addr %0d got %b want %b", i, query_2_i, query_answer_2_o, model_busy(query_2_i)); end
      tick();
      nvec++; if (err_o !== model_err) begin
        nerr++; $display("FAIL rand_err cyc%0d got %b want %b", i, err_o, model_err); end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    query_1_i = 5'd0;
    query_2_i = 5'd0;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    model_err = 1'b0;
    for (int r = 0; r < 32; r++) model_cnt[r] = 0;
    @(negedge clk);
    test_reset();
    test_x0();
    test_commit_release();
    test_multi_pending();
    test_same_cycle();
    test_saturate();
    test_flush();
    test_reset_override();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
